// File: rtl/mem_responder_if.sv
// External memory bus between a CPU initiator and one mem_responder target.
// The initiator drives cs/oe/we/addr/data_in; the target returns data, pad enable, ready and wp_err.
interface mem_responder_if;
  logic        mem_cs;
  logic        mem_oe;
  logic        mem_we;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        mem_ready;
  logic        wp_err;

  modport master (
    output mem_cs, mem_oe, mem_we, addr, data_in,
    input  data_out, data_oe, mem_ready, wp_err
  );

  modport slave (
    input  mem_cs, mem_oe, mem_we, addr, data_in,
    output data_out, data_oe, mem_ready, wp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Wait-stated byte-RAM target for the external memory bus; holds mem_ready until mem_cs drops.
// Optional write protection below WP_LIMIT is enabled by defining MEM_RESP_WP_EN.
module mem_responder #(
  parameter logic [15:0] ADDR_BASE   = 16'h0000,
  parameter int          ADDR_WIDTH  = 13,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] WP_LIMIT    = 16'h0100
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int         RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

`ifdef MEM_RESP_WP_EN
  localparam logic WP_ON = 1'b1;
`else
  localparam logic WP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [3:0]            wcnt_r, wcnt_s;
  logic [ADDR_WIDTH-1:0] offset_r, offset_s;
  logic                  op_we_r, op_we_s;
  logic [7:0]            wdata_r, wdata_s;
  logic                  data_oe_r, data_oe_s;
  logic                  mem_ready_r, mem_ready_s;
  logic                  wp_err_r, wp_err_s;
  logic [7:0]            data_out_r;

  logic                  hit_s;
  logic                  req_s;
  logic                  wp_block_s;
  logic                  ram_we_s;
  logic                  ram_rd_s;

  logic [7:0]            ram_r [RAM_DEPTH];

  // Window decode by comparing only the bits above the window size (works up to ADDR_WIDTH=16).
  assign hit_s      = bus.mem_cs & (16'((bus.addr ^ ADDR_BASE) >> ADDR_WIDTH) == 16'h0000);
  assign req_s      = hit_s & (bus.mem_oe ^ bus.mem_we);
  assign wp_block_s = WP_ON & op_we_r & (16'(offset_r) < WP_LIMIT);

  // Next-state and next-output logic for the bus-cycle FSM.
  always_comb begin
    state_s     = state_r;
    wcnt_s      = wcnt_r;
    offset_s    = offset_r;
    op_we_s     = op_we_r;
    wdata_s     = wdata_r;
    data_oe_s   = data_oe_r;
    mem_ready_s = mem_ready_r;
    wp_err_s    = 1'b0;
    ram_we_s    = 1'b0;
    ram_rd_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        data_oe_s   = 1'b0;
        mem_ready_s = 1'b0;
        if (req_s) begin
          offset_s = bus.addr[ADDR_WIDTH-1:0];
          op_we_s  = bus.mem_we;
          wdata_s  = bus.data_in;
          wcnt_s   = WAIT_INIT;
          state_s  = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (!bus.mem_cs) begin
          wcnt_s  = 4'd0;
          state_s = ST_IDLE;
        end else if (wcnt_r <= 4'd1) begin
          wcnt_s  = 4'd0;
          state_s = ST_ACCESS;
        end else begin
          wcnt_s  = wcnt_r - 4'd1;
          state_s = ST_WAIT;
        end
      end

      ST_ACCESS: begin
        mem_ready_s = 1'b1;
        if (op_we_r) begin
          data_oe_s = 1'b0;
          if (wp_block_s) begin
            wp_err_s = 1'b1;
          end else begin
            ram_we_s = 1'b1;
          end
        end else begin
          ram_rd_s  = 1'b1;
          data_oe_s = 1'b1;
        end
        state_s = ST_HOLD;
      end

      ST_HOLD: begin
        // Everything on the bus except mem_cs is ignored until the initiator releases.
        if (!bus.mem_cs) begin
          data_oe_s   = 1'b0;
          mem_ready_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end

      default: begin
        wcnt_s      = 4'd0;
        data_oe_s   = 1'b0;
        mem_ready_s = 1'b0;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // FSM state, latched request and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wcnt_r      <= 4'd0;
      offset_r    <= '0;
      op_we_r     <= 1'b0;
      wdata_r     <= 8'h00;
      data_oe_r   <= 1'b0;
      mem_ready_r <= 1'b0;
      wp_err_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      wcnt_r      <= wcnt_s;
      offset_r    <= offset_s;
      op_we_r     <= op_we_s;
      wdata_r     <= wdata_s;
      data_oe_r   <= data_oe_s;
      mem_ready_r <= mem_ready_s;
      wp_err_r    <= wp_err_s;
    end
  end

  // Read data register; keeps the last read byte while the pad is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= 8'h00;
    end else if (ram_rd_s) begin
      data_out_r <= ram_r[offset_r];
    end else begin
      data_out_r <= data_out_r;
    end
  end

  // RAM write port; contents survive reset, but a write still in flight at reset is dropped.
  always_ff @(posedge clk) begin
    if (ram_we_s && !rst) begin
      ram_r[offset_r] <= wdata_r;
    end
  end

  assign bus.data_out  = data_out_r;
  assign bus.data_oe   = data_oe_r;
  assign bus.mem_ready = mem_ready_r;
  assign bus.wp_err    = wp_err_r;

endmodule
